// File: rtl/mult_div_unit.sv
// Shared sequential signed multiply/divide engine producing HI/LO results.
// Works on operand magnitudes for WIDTH iterations, then fixes up signs.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mult_start,
  input  logic             div_start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero
);

  typedef enum logic [2:0] {
    IDLE, MULT, DIV, SIGN, DONE
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               sign_a;
  logic               sign_b;
  logic               is_mult;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] mult_next;
  logic [2*WIDTH-1:0] div_next;
  logic               neg;

  assign busy   = (state != IDLE);
  assign acc_hi = acc[2*WIDTH-1:WIDTH];
  assign acc_lo = acc[WIDTH-1:0];
  assign abs_a  = a[WIDTH-1] ? -a : a;
  assign abs_b  = b[WIDTH-1] ? -b : b;
  assign neg    = sign_a ^ sign_b;

  // Multiply: acc = {partial, multiplier}, add on LSB then shift right.
  assign add_sum   = acc[0] ? {1'b0, acc_hi} + {1'b0, mag_a}
                            : {1'b0, acc_hi};
  assign mult_next = {add_sum, acc_lo[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, restoring step.
  assign rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign rem_sub  = rem_sh - {1'b0, mag_b};
  assign rem_ge   = (rem_sh >= {1'b0, mag_b});
  assign div_next = rem_ge
    ? {rem_sub[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1}
    : {rem_sh[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mag_a    <= '0;
      mag_b    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      is_mult  <= 1'b0;
      count    <= '0;
      acc      <= '0;
      done     <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      div_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mult_start || div_start) begin
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            sign_a   <= a[WIDTH-1];
            sign_b   <= b[WIDTH-1];
            is_mult  <= mult_start;
            count    <= '0;
            div_zero <= 1'b0;
            if (mult_start) begin
              acc   <= {{WIDTH{1'b0}}, abs_b};
              state <= MULT;
            end else if (b == '0) begin
              div_zero <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              acc   <= {{WIDTH{1'b0}}, abs_a};
              state <= DIV;
            end
          end
        end
        MULT: begin
          acc   <= mult_next;
          count <= count + CW'(1);
          if (count == LAST) state <= SIGN;
        end
        DIV: begin
          acc   <= div_next;
          count <= count + CW'(1);
          if (count == LAST) state <= SIGN;
        end
        SIGN: begin
          if (is_mult) begin
            {hi_out, lo_out} <= neg ? -acc : acc;
          end else begin
            hi_out <= sign_a ? -acc_hi : acc_hi;
            lo_out <= neg ? -acc_lo : acc_lo;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Inputs driven on negedge, outputs sampled 1ns after posedge.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        mult_start;
  logic        div_start;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_zero;

  int checks = 0;
  int errors = 0;
  int lat;
  int extra;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .mult_start (mult_start),
    .div_start  (div_start),
    .busy       (busy),
    .done       (done),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .div_zero   (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a start, take edge E0, then drop start and scramble operands.
  task automatic start_op(input logic m, input logic d,
                          input logic [31:0] va,
                          input logic [31:0] vb);
    @(negedge clk);
    mult_start = m;
    div_start  = d;
    a          = va;
    b          = vb;
    @(posedge clk);
    #1;
    chk("busy_e0", {63'd0, busy}, 64'd1);
    @(negedge clk);
    mult_start = 1'b0;
    div_start  = 1'b0;
    a          = $urandom;
    b          = $urandom;
  endtask

  // Count edges until done; results must not move before done.
  task automatic wait_done(output int n);
    logic [63:0] prev;
    logic        moved;
    prev  = {hi_out, lo_out};
    moved = 1'b0;
    n     = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (!done && {hi_out, lo_out} !== prev) moved = 1'b1;
    end
    chk("hold_iter", {63'd0, moved}, 64'd0);
  endtask

  task automatic finish_op;
    @(posedge clk);
    #1;
    chk("done_clr", {63'd0, done}, 64'd0);
    chk("busy_clr", {63'd0, busy}, 64'd0);
  endtask

  task automatic count_dones(output int cnt);
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
  endtask

  task automatic run(input string tag, input logic m, input logic d,
                     input logic [31:0] va, input logic [31:0] vb,
                     input logic [63:0] exp);
    int n;
    start_op(m, d, va, vb);
    wait_done(n);
    chk({tag, "_lat"}, 64'(n), 64'd33);
    chk(tag, {hi_out, lo_out}, exp);
    finish_op();
  endtask

  initial begin
    reset      = 1'b1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a          = '0;
    b          = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dz", {63'd0, div_zero}, 64'd0);
    chk("rst_hilo", {hi_out, lo_out}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // 7 * -3, then a start during DONE must be ignored
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    wait_done(lat);
    chk("m1_lat", 64'(lat), 64'd33);
    chk("m1", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFEB);
    @(negedge clk);
    mult_start = 1'b1;
    a          = 32'd2;
    b          = 32'd2;
    @(posedge clk);
    #1;
    chk("dn_busy", {63'd0, busy}, 64'd0);
    chk("dn_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    mult_start = 1'b0;
    @(posedge clk);
    #1;
    chk("dn_ign", {63'd0, busy}, 64'd0);

    run("m2", 1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF,
        64'h3FFFFFFF_00000001);
    run("m3", 1'b1, 1'b0, 32'h80000000, 32'h80000000,
        64'h40000000_00000000);
    run("dovf", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF,
        64'h00000000_80000000);
    run("d1", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,
        64'hFFFFFFFF_FFFFFFFD);
    run("d2", 1'b0, 1'b1, 32'd7, 32'hFFFFFFFE,
        64'h00000001_FFFFFFFD);
    run("d3", 1'b0, 1'b1, 32'd100, 32'd7,
        64'h00000002_0000000E);

    // divide by zero: immediate done, results held
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    chk("dz_done", {63'd0, done}, 64'd1);
    chk("dz_flag", {63'd0, div_zero}, 64'd1);
    chk("dz_hold", {hi_out, lo_out}, 64'h00000002_0000000E);
    finish_op();
    chk("dz_keep", {63'd0, div_zero}, 64'd1);
    start_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("dz_clr", {63'd0, div_zero}, 64'd0);
    wait_done(lat);
    chk("m4", {hi_out, lo_out}, 64'd1);
    finish_op();

    // both starts: multiply wins; re-pulsed div_start ignored
    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    div_start = 1'b1;
    a         = 32'd0;
    b         = 32'd0;
    @(posedge clk);
    #1;
    chk("both_nodz", {63'd0, done}, 64'd0);
    @(negedge clk);
    div_start = 1'b0;
    wait_done(lat);
    chk("both_lat", 64'(lat), 64'd23);
    chk("both", {hi_out, lo_out}, 64'd18);
    finish_op();
    count_dones(extra);
    chk("both_one", 64'(extra), 64'd0);

    // reset in the middle of a divide
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_busy", {63'd0, busy}, 64'd0);
    chk("mr_done", {63'd0, done}, 64'd0);
    chk("mr_hilo", {hi_out, lo_out}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    count_dones(extra);
    chk("mr_nodone", 64'(extra), 64'd0);
    run("m5", 1'b1, 1'b0, 32'd6, 32'd3, 64'd18);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
